// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simon_pkg
// Brief   : Shared Simon Says button codes, controller state encoding and helpers.
// Revision: 1.0 - initial release
// ============================================================================
package simon_pkg;

    // Bit index in the synchronised button vector equals the button code.
    localparam logic [2:0] CODE_UP     = 3'b000;
    localparam logic [2:0] CODE_DOWN   = 3'b001;
    localparam logic [2:0] CODE_LEFT   = 3'b010;
    localparam logic [2:0] CODE_RIGHT  = 3'b011;
    localparam logic [2:0] CODE_CENTER = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PRESS = 3'd1,
        ST_DB_PRESS   = 3'd2,
        ST_WAIT_REL   = 3'd3,
        ST_DB_REL     = 3'd4
    } btn_state_t;

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] enc(input logic [4:0] oh);
        logic [2:0] code;
        code = CODE_UP;
        case (oh)
            5'b00001: code = CODE_UP;
            5'b00010: code = CODE_DOWN;
            5'b00100: code = CODE_LEFT;
            5'b01000: code = CODE_RIGHT;
            5'b10000: code = CODE_CENTER;
            default:  code = CODE_UP;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module  : btn_sync
// Brief   : Parameterised-width two-flop synchroniser for asynchronous inputs.
// Revision: 1.0 - initial release
// ============================================================================
module btn_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/simon_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : simon_button_ctrl
// Brief   : Debounced one-press-per-arm button sequencer with press timeout.
// Revision: 1.0 - initial release
// ============================================================================
module simon_button_ctrl
    import simon_pkg::*;
#(
    parameter int DB_CYCLES      = 1_000_000,
    parameter int TIMEOUT_CYCLES = 300_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       arm,
    input  logic       abort,
    output logic       ready,
    output logic [2:0] code_out,
    output logic       code_valid,
    output logic       timeout
);

    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [4:0] bsync;

    btn_sync #(.WIDTH(5)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   ({btn_center, btn_right, btn_left, btn_down, btn_up}),
        .q   (bsync)
    );

    btn_state_t       state_q, state_d;
    logic [4:0]       sel_q, sel_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             ready_q, ready_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            db_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            code_q    <= CODE_UP;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            db_cnt_q  <= db_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        db_cnt_d  = db_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_WAIT_PRESS;
                    tmo_cnt_d = '0;
                end
            end
            ST_WAIT_PRESS: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (is_onehot(bsync)) begin
                    sel_d    = bsync;
                    db_cnt_d = '0;
                    state_d  = ST_DB_PRESS;
                end
            end
            ST_DB_PRESS: begin
                // Timeout is checked first so it wins over a same-cycle accept.
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bsync != sel_q) begin
                    state_d = ST_WAIT_PRESS;
                end else if (db_cnt_q == DB_LAST) begin
                    code_d  = enc(sel_q);
                    valid_d = 1'b1;
                    state_d = ST_WAIT_REL;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (bsync == 5'd0) begin
                    db_cnt_d = '0;
                    state_d  = ST_DB_REL;
                end
            end
            ST_DB_REL: begin
                if (bsync != 5'd0) begin
                    state_d = ST_WAIT_REL;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            code_d    = code_q;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end

        ready_d = (state_d == ST_IDLE);
    end

    assign ready      = ready_q;
    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire
